// File: rtl/ebus_responder.sv
// EBUS slave responder for a DTE20/RH20-class I/O controller.
// It decodes controller select and function from the EBOX and completes the demand/transfer handshake.
// It captures CONO/DATAO words and drives CONI, DATAI and PI-vector words onto the EBUS data mux.
// It also holds the 3-bit PI assignment and raises the matching PI request line.
module ebus_responder #(
    parameter logic [0:6]  DEV_CS       = 7'o20,
    parameter int          SETTLE       = 2,
    parameter int          DATI_TIMEOUT = 16,
    parameter logic [0:35] INTR_VECTOR  = 36'o0
) (
    input  logic        clk,
    input  logic        eboxResetN,
    input  logic [0:6]  ebusCS,
    input  logic [0:2]  ebusFunc,
    input  logic        ebusDemand,
    input  logic [0:2]  ebusPILevel,
    input  logic [0:35] ebusDataIn,
    output logic        ebusXfer,
    output logic        drvDriving,
    output logic [0:35] drvData,
    output logic [0:7]  ebusPI,
    output logic        devConoStb,
    output logic        devDatoStb,
    output logic [0:35] devWrData,
    input  logic [0:35] devConiData,
    input  logic [0:35] devDatiData,
    input  logic        devDatiReady,
    output logic        devDatiStb,
    input  logic        devIntReq,
    output logic [0:2]  pia
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_DECODE,
        ST_WAITRDY,
        ST_XFER,
        ST_DROP
    } state_t;

    localparam logic [2:0]  FN_CONO  = 3'd0;
    localparam logic [2:0]  FN_CONI  = 3'd1;
    localparam logic [2:0]  FN_DATAO = 3'd2;
    localparam logic [2:0]  FN_DATAI = 3'd3;
    localparam logic [2:0]  FN_PIADR = 3'd4;
    localparam logic [15:0] SETTLE_LAST = 16'(SETTLE);
    localparam logic [15:0] DATI_LAST   = 16'(DATI_TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [0:9]  sel_q, sel_d;
    logic        drvDriving_q, drvDriving_d;
    logic [0:35] drvData_q, drvData_d;
    logic        conoStb_q, conoStb_d;
    logic        datoStb_q, datoStb_d;
    logic        datiStb_q, datiStb_d;
    logic [0:35] wrData_q, wrData_d;
    logic [0:2]  pia_q, pia_d;
    logic [0:7]  piReq;

    // The low three CONI status bits are always replaced by the PI assignment.
    logic unusedConi;
    assign unusedConi = ^devConiData[33:35];

    // State, counters and all registered outputs; reset aborts any transaction immediately.
    always_ff @(posedge clk or negedge eboxResetN) begin
        if (!eboxResetN) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            sel_q        <= '0;
            drvDriving_q <= 1'b0;
            drvData_q    <= '0;
            conoStb_q    <= 1'b0;
            datoStb_q    <= 1'b0;
            datiStb_q    <= 1'b0;
            wrData_q     <= '0;
            pia_q        <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            sel_q        <= sel_d;
            drvDriving_q <= drvDriving_d;
            drvData_q    <= drvData_d;
            conoStb_q    <= conoStb_d;
            datoStb_q    <= datoStb_d;
            datiStb_q    <= datiStb_d;
            wrData_q     <= wrData_d;
            pia_q        <= pia_d;
        end
    end

    // Handshake sequencing: settle, decode, optional wait for read data, hold transfer until demand drops.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        sel_d        = sel_q;
        drvDriving_d = drvDriving_q;
        drvData_d    = drvData_q;
        conoStb_d    = 1'b0;
        datoStb_d    = 1'b0;
        datiStb_d    = 1'b0;
        wrData_d     = wrData_q;
        pia_d        = pia_q;

        case (state_q)
            ST_IDLE: begin
                if (ebusDemand) begin
                    state_d = ST_SETTLE;
                    cnt_d   = '0;
                    sel_d   = {ebusCS, ebusFunc};
                end
            end

            ST_SETTLE: begin
                if (!ebusDemand) begin
                    state_d = ST_IDLE;
                end else if ({ebusCS, ebusFunc} != sel_q) begin
                    cnt_d = '0;
                    sel_d = {ebusCS, ebusFunc};
                end else if (cnt_q == SETTLE_LAST) begin
                    state_d = ST_DECODE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end

            ST_DECODE: begin
                if (!ebusDemand) begin
                    state_d = ST_IDLE;
                end else if ((ebusFunc >= 3'd5) || ((ebusCS != DEV_CS) && (ebusFunc != FN_PIADR))) begin
                    state_d = ST_DROP;
                end else begin
                    case (ebusFunc)
                        FN_CONO: begin
                            wrData_d  = ebusDataIn;
                            pia_d     = ebusDataIn[33:35];
                            conoStb_d = 1'b1;
                            state_d   = ST_XFER;
                        end
                        FN_DATAO: begin
                            wrData_d  = ebusDataIn;
                            datoStb_d = 1'b1;
                            state_d   = ST_XFER;
                        end
                        FN_CONI: begin
                            drvData_d    = {devConiData[0:32], pia_q};
                            drvDriving_d = 1'b1;
                            state_d      = ST_XFER;
                        end
                        FN_PIADR: begin
                            if (devIntReq && (pia_q != 3'd0) && (pia_q == ebusPILevel)) begin
                                drvData_d    = INTR_VECTOR;
                                drvDriving_d = 1'b1;
                                state_d      = ST_XFER;
                            end else begin
                                state_d = ST_DROP;
                            end
                        end
                        FN_DATAI: begin
                            cnt_d   = '0;
                            state_d = ST_WAITRDY;
                        end
                        default: begin
                            state_d = ST_DROP;
                        end
                    endcase
                end
            end

            ST_WAITRDY: begin
                if (!ebusDemand) begin
                    state_d = ST_IDLE;
                end else if (devDatiReady) begin
                    drvData_d    = devDatiData;
                    drvDriving_d = 1'b1;
                    datiStb_d    = 1'b1;
                    state_d      = ST_XFER;
                end else if (cnt_q == DATI_LAST) begin
                    state_d = ST_DROP;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end

            ST_XFER: begin
                if (!ebusDemand) begin
                    drvDriving_d = 1'b0;
                    drvData_d    = '0;
                    state_d      = ST_IDLE;
                end
            end

            ST_DROP: begin
                if (!ebusDemand) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // PI request follows the assignment and device request directly, independent of the handshake.
    always_comb begin
        piReq = '0;
        if (devIntReq && (pia_q != 3'd0)) begin
            piReq[pia_q] = 1'b1;
        end
    end

    assign ebusXfer   = (state_q == ST_XFER);
    assign drvDriving = drvDriving_q;
    assign drvData    = drvData_q;
    assign ebusPI     = piReq;
    assign devConoStb = conoStb_q;
    assign devDatoStb = datoStb_q;
    assign devDatiStb = datiStb_q;
    assign devWrData  = wrData_q;
    assign pia        = pia_q;

endmodule

// File: tb/tb_ebus_responder.sv
// Testbench for ebus_responder: directed vector table, randomized transactions against a
// transaction-level reference model, and a mid-transfer reset sequence.
module tb_ebus_responder;

    localparam int          SETTLE       = 2;
    localparam int          DATI_TIMEOUT = 16;
    localparam int          BUDGET       = 40;
    localparam logic [35:0] VEC          = 36'o0;

    logic        clk = 1'b0;
    logic        eboxResetN = 1'b0;
    logic [0:6]  ebusCS = '0;
    logic [0:2]  ebusFunc = '0;
    logic        ebusDemand = 1'b0;
    logic [0:2]  ebusPILevel = '0;
    logic [0:35] ebusDataIn = '0;
    logic        ebusXfer;
    logic        drvDriving;
    logic [0:35] drvData;
    logic [0:7]  ebusPI;
    logic        devConoStb;
    logic        devDatoStb;
    logic [0:35] devWrData;
    logic [0:35] devConiData = '0;
    logic [0:35] devDatiData = '0;
    logic        devDatiReady = 1'b0;
    logic        devDatiStb;
    logic        devIntReq = 1'b0;
    logic [0:2]  pia;

    int checks = 0;
    int failures = 0;

    // Free-running EBOX clock.
    always #5 clk = ~clk;

    ebus_responder #(
        .DEV_CS(7'o20),
        .SETTLE(SETTLE),
        .DATI_TIMEOUT(DATI_TIMEOUT),
        .INTR_VECTOR(VEC)
    ) dut (
        .clk(clk),
        .eboxResetN(eboxResetN),
        .ebusCS(ebusCS),
        .ebusFunc(ebusFunc),
        .ebusDemand(ebusDemand),
        .ebusPILevel(ebusPILevel),
        .ebusDataIn(ebusDataIn),
        .ebusXfer(ebusXfer),
        .drvDriving(drvDriving),
        .drvData(drvData),
        .ebusPI(ebusPI),
        .devConoStb(devConoStb),
        .devDatoStb(devDatoStb),
        .devWrData(devWrData),
        .devConiData(devConiData),
        .devDatiData(devDatiData),
        .devDatiReady(devDatiReady),
        .devDatiStb(devDatiStb),
        .devIntReq(devIntReq),
        .pia(pia)
    );

    typedef struct {
        logic [6:0]  cs;
        logic [2:0]  func;
        logic [35:0] data;
        logic [35:0] coni;
        logic [35:0] dati;
        int          rd;
        logic [2:0]  level;
        logic        intReq;
        logic        expXfer;
        int          expLat;
        logic        expDriving;
        logic [35:0] expDrv;
        logic [2:0]  expPia;
        logic [35:0] expWr;
    } vec_t;

    logic        obsXfer;
    int          obsLat;
    logic        obsDriving;
    logic [35:0] obsDrv;
    logic        obsStable;
    logic        obsIdleAfter;
    int          obsCono;
    int          obsDato;
    int          obsDati;
    logic [2:0]  obsPia;
    logic [35:0] obsWr;
    logic [7:0]  obsPI;

    function automatic vec_t mk(input logic [6:0] cs, input logic [2:0] func, input logic [35:0] data,
                                input logic [35:0] coni, input logic [35:0] dati, input int rd,
                                input logic [2:0] level, input logic intReq, input logic expXfer,
                                input int expLat, input logic expDriving, input logic [35:0] expDrv,
                                input logic [2:0] expPia, input logic [35:0] expWr);
        vec_t v;
        v.cs = cs; v.func = func; v.data = data; v.coni = coni; v.dati = dati; v.rd = rd;
        v.level = level; v.intReq = intReq; v.expXfer = expXfer; v.expLat = expLat;
        v.expDriving = expDriving; v.expDrv = expDrv; v.expPia = expPia; v.expWr = expWr;
        return v;
    endfunction

    // Transaction-level reference: who answers, what word appears, what state the device keeps.
    function automatic vec_t model(input vec_t v, input logic [2:0] curPia, input logic [35:0] curWr);
        vec_t r;
        logic csHit;
        r = v;
        csHit = (v.cs == 7'o20);
        r.expXfer = 1'b0; r.expLat = SETTLE + 2; r.expDriving = 1'b0; r.expDrv = '0;
        r.expPia = curPia; r.expWr = curWr;
        case (v.func)
            3'd0: if (csHit) begin r.expXfer = 1'b1; r.expWr = v.data; r.expPia = 3'(v.data % 8); end
            3'd1: if (csHit) begin r.expXfer = 1'b1; r.expDriving = 1'b1; r.expDrv = (v.coni & ~36'o7) | 36'(curPia); end
            3'd2: if (csHit) begin r.expXfer = 1'b1; r.expWr = v.data; end
            3'd3: if (csHit && v.rd <= SETTLE + 1 + DATI_TIMEOUT) begin
                r.expXfer = 1'b1; r.expDriving = 1'b1; r.expDrv = v.dati;
                r.expLat = (v.rd + 1 > SETTLE + 3) ? v.rd + 1 : SETTLE + 3;
            end
            3'd4: if (v.intReq && curPia != 3'd0 && curPia == v.level) begin
                r.expXfer = 1'b1; r.expDriving = 1'b1; r.expDrv = VEC;
            end
            default: ;
        endcase
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [35:0] actual, input logic [35:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0o expected=%0o", name, actual, expected);
        end
    endtask

    task automatic countStrobes();
        obsCono += int'(devConoStb);
        obsDato += int'(devDatoStb);
        obsDati += int'(devDatiStb);
    endtask

    // Runs one full demand cycle on the bus and records what the responder did.
    task automatic applyStimulus(input vec_t v);
        @(negedge clk);
        ebusCS = v.cs; ebusFunc = v.func; ebusDataIn = v.data; devConiData = v.coni;
        devDatiData = v.dati; ebusPILevel = v.level; devIntReq = v.intReq; devDatiReady = 1'b0;
        ebusDemand = 1'b1;
        obsXfer = 1'b0; obsLat = -1; obsStable = 1'b1; obsCono = 0; obsDato = 0; obsDati = 0;
        for (int k = 0; k < BUDGET; k++) begin
            @(posedge clk);
            @(negedge clk);
            countStrobes();
            if (ebusXfer) begin
                obsXfer = 1'b1;
                obsLat = k;
                break;
            end
            if (k >= v.rd) devDatiReady = 1'b1;
        end
        obsDriving = drvDriving;
        obsDrv = drvData;
        if (obsXfer) begin
            for (int h = 0; h < 2; h++) begin
                @(posedge clk);
                @(negedge clk);
                countStrobes();
                if (ebusXfer !== 1'b1 || drvDriving !== obsDriving || drvData !== obsDrv) obsStable = 1'b0;
            end
        end
        ebusDemand = 1'b0;
        devDatiReady = 1'b0;
        @(posedge clk);
        @(negedge clk);
        countStrobes();
        obsIdleAfter = (ebusXfer === 1'b0) && (drvDriving === 1'b0) && (drvData === 36'o0);
        @(posedge clk);
        @(negedge clk);
        countStrobes();
        obsPia = pia;
        obsWr = devWrData;
        obsPI = ebusPI;
    endtask

    task automatic checkTxn(input string tag, input vec_t v);
        logic [7:0] expPI;
        expPI = (v.intReq && v.expPia != 3'd0) ? (8'h80 >> v.expPia) : 8'h00;
        checkOutput({tag, ".xfer"}, 36'(obsXfer), 36'(v.expXfer));
        checkOutput({tag, ".latency"}, 36'(obsLat), 36'(v.expXfer ? v.expLat : -1));
        checkOutput({tag, ".stable"}, 36'(obsStable), 36'(1));
        checkOutput({tag, ".driving"}, 36'(obsDriving), 36'(v.expDriving));
        checkOutput({tag, ".drvData"}, obsDrv, v.expDrv);
        checkOutput({tag, ".idleAfter"}, 36'(obsIdleAfter), 36'(1));
        checkOutput({tag, ".conoStb"}, 36'(obsCono), 36'(v.expXfer && v.func == 3'd0));
        checkOutput({tag, ".datoStb"}, 36'(obsDato), 36'(v.expXfer && v.func == 3'd2));
        checkOutput({tag, ".datiStb"}, 36'(obsDati), 36'(v.expXfer && v.func == 3'd3));
        checkOutput({tag, ".pia"}, 36'(obsPia), 36'(v.expPia));
        checkOutput({tag, ".wrData"}, obsWr, v.expWr);
        checkOutput({tag, ".ebusPI"}, 36'(obsPI), 36'(expPI));
    endtask

    vec_t tbl[15];

    initial begin
        vec_t v;
        logic [2:0]  mPia;
        logic [35:0] mWr;

        tbl[0]  = mk(7'o20, 3'd0, 36'o5, 36'o0, 36'o0, 255, 3'd0, 1'b1, 1'b1, 4, 1'b0, 36'o0, 3'd5, 36'o5);
        tbl[1]  = mk(7'o20, 3'd1, 36'o0, 36'o123456701234, 36'o0, 255, 3'd0, 1'b1, 1'b1, 4, 1'b1, 36'o123456701235, 3'd5, 36'o5);
        tbl[2]  = mk(7'o20, 3'd3, 36'o0, 36'o0, 36'o777000111222, 5, 3'd0, 1'b0, 1'b1, 6, 1'b1, 36'o777000111222, 3'd5, 36'o5);
        tbl[3]  = mk(7'o20, 3'd3, 36'o0, 36'o0, 36'o777000111222, 255, 3'd0, 1'b0, 1'b0, 0, 1'b0, 36'o0, 3'd5, 36'o5);
        tbl[4]  = mk(7'o21, 3'd0, 36'o7, 36'o0, 36'o0, 255, 3'd0, 1'b1, 1'b0, 0, 1'b0, 36'o0, 3'd5, 36'o5);
        tbl[5]  = mk(7'o20, 3'd6, 36'o7, 36'o0, 36'o0, 255, 3'd0, 1'b1, 1'b0, 0, 1'b0, 36'o0, 3'd5, 36'o5);
        tbl[6]  = mk(7'o20, 3'd0, 36'o3, 36'o0, 36'o0, 255, 3'd0, 1'b1, 1'b1, 4, 1'b0, 36'o0, 3'd3, 36'o3);
        tbl[7]  = mk(7'o00, 3'd4, 36'o0, 36'o0, 36'o0, 255, 3'd3, 1'b1, 1'b1, 4, 1'b1, VEC, 3'd3, 36'o3);
        tbl[8]  = mk(7'o00, 3'd4, 36'o0, 36'o0, 36'o0, 255, 3'd4, 1'b1, 1'b0, 0, 1'b0, 36'o0, 3'd3, 36'o3);
        tbl[9]  = mk(7'o20, 3'd2, 36'o111222333444, 36'o0, 36'o0, 255, 3'd0, 1'b0, 1'b1, 4, 1'b0, 36'o0, 3'd3, 36'o111222333444);
        tbl[10] = mk(7'o20, 3'd3, 36'o0, 36'o0, 36'o000111222333, 19, 3'd0, 1'b0, 1'b1, 20, 1'b1, 36'o000111222333, 3'd3, 36'o111222333444);
        tbl[11] = mk(7'o20, 3'd3, 36'o0, 36'o0, 36'o000111222333, 20, 3'd0, 1'b0, 1'b0, 0, 1'b0, 36'o0, 3'd3, 36'o111222333444);
        tbl[12] = mk(7'o00, 3'd4, 36'o0, 36'o0, 36'o0, 255, 3'd3, 1'b0, 1'b0, 0, 1'b0, 36'o0, 3'd3, 36'o111222333444);
        tbl[13] = mk(7'o20, 3'd0, 36'o0, 36'o0, 36'o0, 255, 3'd0, 1'b1, 1'b1, 4, 1'b0, 36'o0, 3'd0, 36'o0);
        tbl[14] = mk(7'o00, 3'd4, 36'o0, 36'o0, 36'o0, 255, 3'd0, 1'b1, 1'b0, 0, 1'b0, 36'o0, 3'd0, 36'o0);

        devIntReq = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("reset.xfer", 36'(ebusXfer), 36'(0));
        checkOutput("reset.driving", 36'(drvDriving), 36'(0));
        checkOutput("reset.drvData", drvData, 36'o0);
        checkOutput("reset.strobes", 36'({devConoStb, devDatoStb, devDatiStb}), 36'(0));
        checkOutput("reset.wrData", devWrData, 36'o0);
        checkOutput("reset.pia", 36'(pia), 36'(0));
        checkOutput("reset.ebusPI", 36'(ebusPI), 36'(0));
        eboxResetN = 1'b1;
        devIntReq = 1'b0;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 15; i++) begin
            applyStimulus(tbl[i]);
            checkTxn($sformatf("tbl%0d", i), tbl[i]);
        end

        mPia = tbl[14].expPia;
        mWr = tbl[14].expWr;
        for (int i = 0; i < 30; i++) begin
            v.cs = ($urandom_range(0, 1) == 0) ? 7'o20 : 7'($urandom);
            v.func = 3'($urandom_range(0, 7));
            v.data = {4'($urandom), 32'($urandom)};
            v.coni = {4'($urandom), 32'($urandom)};
            v.dati = {4'($urandom), 32'($urandom)};
            v.rd = ($urandom_range(0, 3) == 0) ? 255 : int'($urandom_range(0, 24));
            v.level = ($urandom_range(0, 1) == 0) ? mPia : 3'($urandom);
            v.intReq = 1'($urandom);
            v = model(v, mPia, mWr);
            applyStimulus(v);
            checkTxn($sformatf("rnd%0d", i), v);
            mPia = v.expPia;
            mWr = v.expWr;
        end

        v = model(mk(7'o20, 3'd0, 36'o6, 0, 0, 255, 0, 1'b1, 0, 0, 0, 0, 0, 0), mPia, mWr);
        applyStimulus(v);
        checkTxn("rst.setup", v);

        @(negedge clk);
        ebusCS = 7'o20; ebusFunc = 3'd1; devIntReq = 1'b1; devConiData = 36'o5555;
        ebusDemand = 1'b1;
        repeat (SETTLE + 3) @(negedge clk);
        checkOutput("rst.preXfer", 36'(ebusXfer), 36'(1));
        checkOutput("rst.preDriving", 36'(drvDriving), 36'(1));
        #2 eboxResetN = 1'b0;
        #1;
        checkOutput("rst.xfer", 36'(ebusXfer), 36'(0));
        checkOutput("rst.driving", 36'(drvDriving), 36'(0));
        checkOutput("rst.pia", 36'(pia), 36'(0));
        checkOutput("rst.ebusPI", 36'(ebusPI), 36'(0));
        @(negedge clk);
        ebusDemand = 1'b0;
        eboxResetN = 1'b1;
        repeat (2) @(negedge clk);
        mPia = 3'd0;
        mWr = 36'o0;

        v = model(mk(7'o20, 3'd0, 36'o404040404042, 0, 0, 255, 0, 1'b1, 0, 0, 0, 0, 0, 0), mPia, mWr);
        applyStimulus(v);
        checkTxn("rst.after", v);
        mPia = v.expPia;
        mWr = v.expWr;
        v = model(mk(7'o20, 3'd1, 0, 36'o700000000000, 0, 255, 0, 1'b1, 0, 0, 0, 0, 0, 0), mPia, mWr);
        applyStimulus(v);
        checkTxn("rst.coni", v);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
